// File: rtl/delayed_branch_sched.sv
// rtl/delayed_branch_sched.sv - delayed-branch queue, flag-timed condition check and p0 re-injection
// Optional feature macro DBS_PERF_CNT_EN adds issued/discarded event counters.
module delayed_branch_sched #(
  parameter int DEPTH    = 4,
  parameter int FLAG_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_next_in,
  input  logic        p0_valid_in,
  input  logic [15:0] p0_delayed_B_in,
  input  logic [2:0]  p0_delayed_cond_in,
  input  logic        p1_valid_in,
  input  logic [15:0] p1_delayed_B_in,
  input  logic [2:0]  p1_delayed_cond_in,
  input  logic        N,
  input  logic        V,
  input  logic        Z,
  input  logic        flags_valid_in,
  input  logic        halted_in,
  output logic [15:0] inject_IR_out,
  output logic        p0_do_delayed_B,
  output logic        p1_do_delayed_B,
  output logic        flush_out,
  output logic        full_out,
`ifdef DBS_PERF_CNT_EN
  output logic [15:0] issued_cnt_out,
  output logic [15:0] discarded_cnt_out,
`endif
  output logic        overflow_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int AW = $clog2(FLAG_LAT + 1);
  localparam logic [AW-1:0] AGE_MAX = AW'(FLAG_LAT);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [2:0]    COND_NV = 3'd0;

  typedef enum logic [1:0] {IDLE, WAIT, EVAL, ISSUE} state_t;

  state_t        state_q, state_d;
  logic [15:0]   word_q [DEPTH];
  logic [15:0]   word_d [DEPTH];
  logic [2:0]    cond_q [DEPTH];
  logic [2:0]    cond_d [DEPTH];
  logic [AW-1:0] age_q  [DEPTH];
  logic [AW-1:0] age_d  [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   inject_q, inject_d;
  logic [2:0]    flags_q, flags_d;
  logic          ovf_q, ovf_d;

  logic          run, advance, hit, flush, pop, cap_ok;
  logic          p0_want, p1_want, p0_push, p1_push;
  logic [CW-1:0] free_slots;
  logic [PW-1:0] p1_slot;

  // flags packed as {N, V, Z}
  function automatic logic cond_hit(input logic [2:0] c, input logic [2:0] f);
    logic lt;
    lt = f[2] ^ f[1];
    case (c)
      3'd0:    cond_hit = 1'b0;
      3'd1:    cond_hit = 1'b1;
      3'd2:    cond_hit = f[0];
      3'd3:    cond_hit = ~f[0];
      3'd4:    cond_hit = lt;
      3'd5:    cond_hit = lt | f[0];
      3'd6:    cond_hit = ~(lt | f[0]);
      default: cond_hit = ~lt;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    cond_d   = cond_q;
    age_d    = age_q;
    inject_d = inject_q;
    flags_d  = flags_q;

    run     = ~halted_in;
    advance = run & fetch_next_in;
    hit     = cond_hit(cond_q[head_q], flags_q);
    flush   = run & (state_q == EVAL) & hit;
    pop     = run & (state_q == EVAL) & ~hit;

    // A flush squashes the same-cycle lane captures as wrong-path.
    cap_ok     = advance & (state_q != ISSUE) & ~flush;
    p0_want    = cap_ok & p0_valid_in & (p0_delayed_cond_in != COND_NV);
    p1_want    = cap_ok & p1_valid_in & (p1_delayed_cond_in != COND_NV);
    free_slots = DEPTH_C - count_q;
    p0_push    = p0_want & (free_slots != '0);
    p1_push    = p1_want & (free_slots > CW'(p0_push));
    p1_slot    = tail_q + PW'(p0_push);

    for (int i = 0; i < DEPTH; i++) begin
      if (advance && age_q[i] != AGE_MAX) begin
        age_d[i] = age_q[i] + 1'b1;
      end
    end

    if (p0_push) begin
      word_d[tail_q] = p0_delayed_B_in;
      cond_d[tail_q] = p0_delayed_cond_in;
      age_d[tail_q]  = '0;
    end
    if (p1_push) begin
      word_d[p1_slot] = p1_delayed_B_in;
      cond_d[p1_slot] = p1_delayed_cond_in;
      age_d[p1_slot]  = '0;
    end

    tail_d  = tail_q + PW'(p0_push) + PW'(p1_push);
    head_d  = head_q + PW'(pop);
    count_d = count_q + CW'(p0_push) + CW'(p1_push) - CW'(pop);
    ovf_d   = ovf_q | (p0_want & ~p0_push) | (p1_want & ~p1_push);

    // Everything behind a taken branch is wrong-path, so the whole queue goes.
    if (flush) begin
      head_d   = '0;
      tail_d   = '0;
      count_d  = '0;
      inject_d = word_q[head_q];
    end

    case (state_q)
      IDLE: begin
        if (p0_push || p1_push) state_d = WAIT;
      end
      WAIT: begin
        if (run && flags_valid_in && age_q[head_q] == AGE_MAX) begin
          state_d = EVAL;
          flags_d = {N, V, Z};
        end
      end
      EVAL: begin
        if (flush) begin
          state_d = ISSUE;
        end else if (pop) begin
          state_d = (count_d != '0) ? WAIT : IDLE;
        end
      end
      ISSUE: begin
        if (advance) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      inject_q <= '0;
      flags_q  <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        word_q[i] <= '0;
        cond_q[i] <= '0;
        age_q[i]  <= '0;
      end
    end else begin
      state_q  <= state_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      inject_q <= inject_d;
      flags_q  <= flags_d;
      ovf_q    <= ovf_d;
      word_q   <= word_d;
      cond_q   <= cond_d;
      age_q    <= age_d;
    end
  end

`ifdef DBS_PERF_CNT_EN
  logic [15:0] issued_q, issued_d, discarded_q, discarded_d;

  always_comb begin
    issued_d    = issued_q;
    discarded_d = discarded_q;
    if (flush && issued_q != 16'hFFFF) issued_d = issued_q + 16'd1;
    if (pop && discarded_q != 16'hFFFF) discarded_d = discarded_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issued_q    <= '0;
      discarded_q <= '0;
    end else begin
      issued_q    <= issued_d;
      discarded_q <= discarded_d;
    end
  end

  assign issued_cnt_out    = issued_q;
  assign discarded_cnt_out = discarded_q;
`endif

  assign flush_out       = flush;
  assign p0_do_delayed_B = (state_q == ISSUE);
  assign inject_IR_out   = (state_q == ISSUE) ? inject_q : 16'h0000;
  assign p1_do_delayed_B = 1'b0;
  assign full_out        = (count_q == DEPTH_C);
  assign overflow_out    = ovf_q;

endmodule

// File: tb/tb_delayed_branch_sched.sv
// tb/tb_delayed_branch_sched.sv - queue-level reference model plus directed scenarios for delayed_branch_sched
module tb_delayed_branch_sched;
  localparam int DEPTH    = 4;
  localparam int FLAG_LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_next_in = 1'b0;
  logic        p0_valid_in = 1'b0, p1_valid_in = 1'b0;
  logic [15:0] p0_delayed_B_in = '0, p1_delayed_B_in = '0;
  logic [2:0]  p0_delayed_cond_in = '0, p1_delayed_cond_in = '0;
  logic        N = 1'b0, V = 1'b0, Z = 1'b0;
  logic        flags_valid_in = 1'b0, halted_in = 1'b0;
  logic [15:0] inject_IR_out;
  logic        p0_do_delayed_B, p1_do_delayed_B, flush_out, full_out, overflow_out;
`ifdef DBS_PERF_CNT_EN
  logic [15:0] issued_cnt_out, discarded_cnt_out;
`endif

  always #5 clk = ~clk;

  delayed_branch_sched #(.DEPTH(DEPTH), .FLAG_LAT(FLAG_LAT)) dut (
    .clk(clk), .rst(rst), .fetch_next_in(fetch_next_in),
    .p0_valid_in(p0_valid_in), .p0_delayed_B_in(p0_delayed_B_in), .p0_delayed_cond_in(p0_delayed_cond_in),
    .p1_valid_in(p1_valid_in), .p1_delayed_B_in(p1_delayed_B_in), .p1_delayed_cond_in(p1_delayed_cond_in),
    .N(N), .V(V), .Z(Z), .flags_valid_in(flags_valid_in), .halted_in(halted_in),
    .inject_IR_out(inject_IR_out), .p0_do_delayed_B(p0_do_delayed_B), .p1_do_delayed_B(p1_do_delayed_B),
    .flush_out(flush_out), .full_out(full_out),
`ifdef DBS_PERF_CNT_EN
    .issued_cnt_out(issued_cnt_out), .discarded_cnt_out(discarded_cnt_out),
`endif
    .overflow_out(overflow_out)
  );

  typedef struct { logic [15:0] w; logic [2:0] c; int age; } ent_t;
  ent_t        mq[$];
  bit          m_eval, m_issue, m_ovf, started;
  logic [2:0]  m_flags;
  logic [15:0] m_inj;
  int          checks = 0, errors = 0;

  function automatic bit spec_cond(input logic [2:0] c, input logic n, input logic v, input logic z);
    bit lt;
    lt = n ^ v;
    case (c)
      3'd0: return 1'b0;
      3'd1: return 1'b1;
      3'd2: return z;
      3'd3: return !z;
      3'd4: return lt;
      3'd5: return lt | z;
      3'd6: return !(lt | z);
      default: return !lt;
    endcase
  endfunction

  function automatic bit m_flush();
    if (!m_eval || halted_in || mq.size() == 0) return 1'b0;
    return spec_cond(mq[0].c, m_flags[2], m_flags[1], m_flags[0]);
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Queue-level model: entries live in an SV queue; "waiting" is simply a non-empty queue.
  always @(posedge clk) begin : model
    int old_size, room;
    bit was_issue, go_eval, f, adv;
    started = 1'b1;
    if (rst) begin
      mq.delete();
      m_eval = 0; m_issue = 0; m_ovf = 0; m_inj = '0; m_flags = '0;
    end else if (!halted_in) begin
      old_size  = mq.size();
      was_issue = m_issue;
      adv       = fetch_next_in;
      f         = m_flush();
      go_eval   = !m_eval && !m_issue && old_size > 0 && mq[0].age == FLAG_LAT && flags_valid_in;
      if (adv) foreach (mq[i]) if (mq[i].age < FLAG_LAT) mq[i].age++;
      if (m_eval) begin
        if (f) begin
          m_inj = mq[0].w;
          mq.delete();
          m_issue = 1;
        end else begin
          void'(mq.pop_front());
        end
        m_eval = 0;
      end
      if (go_eval) begin
        m_eval  = 1;
        m_flags = {N, V, Z};
      end
      if (was_issue && adv) m_issue = 0;
      if (adv && !was_issue && !f) begin
        room = DEPTH - old_size;
        if (p0_valid_in && p0_delayed_cond_in != 3'd0) begin
          if (room > 0) begin
            mq.push_back('{p0_delayed_B_in, p0_delayed_cond_in, 0});
            room--;
          end else m_ovf = 1;
        end
        if (p1_valid_in && p1_delayed_cond_in != 3'd0) begin
          if (room > 0) mq.push_back('{p1_delayed_B_in, p1_delayed_cond_in, 0});
          else m_ovf = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("flush_out", {15'd0, flush_out}, {15'd0, m_flush()});
      chk("p0_do_delayed_B", {15'd0, p0_do_delayed_B}, {15'd0, m_issue});
      chk("inject_IR_out", inject_IR_out, m_issue ? m_inj : 16'h0000);
      chk("p1_do_delayed_B", {15'd0, p1_do_delayed_B}, 16'h0000);
      chk("full_out", {15'd0, full_out}, {15'd0, mq.size() == DEPTH});
      chk("overflow_out", {15'd0, overflow_out}, {15'd0, m_ovf});
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic lane0(input logic vld, input logic [15:0] b, input logic [2:0] c);
    p0_valid_in = vld; p0_delayed_B_in = b; p0_delayed_cond_in = c;
  endtask

  task automatic lane1(input logic vld, input logic [15:0] b, input logic [2:0] c);
    p1_valid_in = vld; p1_delayed_B_in = b; p1_delayed_cond_in = c;
  endtask

  // Capture one p0 branch, age it to FLAG_LAT and present flags so the next cycle is EVAL.
  task automatic to_eval(input logic [15:0] b, input logic [2:0] c, input logic z);
    fetch_next_in = 1; lane0(1, b, c); tick();
    lane0(0, '0, 0); tick(); tick();
    fetch_next_in = 0; flags_valid_in = 1; Z = z; tick();
    flags_valid_in = 0;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin : stim
    logic [15:0] seen;
    int injects;
    tick(); tick();
    chk("rst_p0_do", {15'd0, p0_do_delayed_B}, 16'h0000);
    chk("rst_inject", inject_IR_out, 16'h0000);
    chk("rst_ovf", {15'd0, overflow_out}, 16'h0000);
    rst = 0; tick();

    // AL branch: flush one cycle, then inject
    to_eval(16'h2031, 3'd1, 1'b0);
    chk("t1_flush", {15'd0, flush_out}, 16'h0001);
    tick();
    chk("t1_flush_gone", {15'd0, flush_out}, 16'h0000);
    chk("t1_inject", inject_IR_out, 16'h2031);
    chk("t1_p0_do", {15'd0, p0_do_delayed_B}, 16'h0001);
    fetch_next_in = 1; tick();
    chk("t1_release", {15'd0, p0_do_delayed_B}, 16'h0000);
    fetch_next_in = 0;

    // p1 EQ with Z=0: popped without flush
    fetch_next_in = 1; lane1(1, 16'hA044, 3'd2); tick();
    lane1(0, '0, 0); tick(); tick();
    fetch_next_in = 0; flags_valid_in = 1; Z = 0; tick();
    flags_valid_in = 0;
    chk("t2_no_flush", {15'd0, flush_out}, 16'h0000);
    tick();
    chk("t2_no_inject", {15'd0, p0_do_delayed_B}, 16'h0000);

    // p0 NE + p1 AL together, Z=0: p0 issues, p1 is cleared
    fetch_next_in = 1; lane0(1, 16'hB010, 3'd3); lane1(1, 16'hB112, 3'd1); tick();
    lane0(0, '0, 0); lane1(0, '0, 0); tick(); tick();
    fetch_next_in = 0; flags_valid_in = 1; Z = 0; tick();
    flags_valid_in = 0;
    chk("t3_flush", {15'd0, flush_out}, 16'h0001);
    tick();
    chk("t3_inject", inject_IR_out, 16'hB010);
    fetch_next_in = 1; tick();
    flags_valid_in = 1;
    for (int k = 0; k < 4; k++) begin
      chk("t3_single_inject", {15'd0, p0_do_delayed_B | flush_out}, 16'h0000);
      tick();
    end
    flags_valid_in = 0;

    // fill to DEPTH, fifth capture overflows; order of the first four survives
    fetch_next_in = 1; Z = 0;
    lane0(1, 16'h4401, 3'd2); lane1(1, 16'h4402, 3'd2); tick();
    lane0(1, 16'h4403, 3'd2); lane1(1, 16'h4404, 3'd1); tick();
    chk("t4_full", {15'd0, full_out}, 16'h0001);
    chk("t4_no_ovf_yet", {15'd0, overflow_out}, 16'h0000);
    lane0(1, 16'h4405, 3'd1); lane1(0, '0, 0); tick();
    lane0(0, '0, 0);
    chk("t4_ovf", {15'd0, overflow_out}, 16'h0001);
    flags_valid_in = 1;
    seen = '0; injects = 0;
    for (int k = 0; k < 30; k++) begin
      if (p0_do_delayed_B) begin
        injects++;
        if (seen == 16'h0000) seen = inject_IR_out;
      end
      tick();
    end
    flags_valid_in = 0;
    chk("t4_fourth_issued", seen, 16'h4404);
    chk("t4_inject_count", 16'(injects), 16'd1);
    chk("t4_ovf_sticky", {15'd0, overflow_out}, 16'h0001);

    // hit with fetch stalled: held 3 cycles, released on first advance
    to_eval(16'h6060, 3'd1, 1'b0);
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("t5_hold", {15'd0, p0_do_delayed_B}, 16'h0001);
      chk("t5_hold_ir", inject_IR_out, 16'h6060);
      if (k < 2) tick();
    end
    fetch_next_in = 1; tick();
    chk("t5_release", {15'd0, p0_do_delayed_B}, 16'h0000);
    fetch_next_in = 0;

    // reset mid-ISSUE
    to_eval(16'h7070, 3'd7, 1'b0);
    tick();
    chk("t6_in_issue", {15'd0, p0_do_delayed_B}, 16'h0001);
    rst = 1; tick();
    chk("t6_p0_do", {15'd0, p0_do_delayed_B}, 16'h0000);
    chk("t6_inject", inject_IR_out, 16'h0000);
    chk("t6_full", {15'd0, full_out}, 16'h0000);
    chk("t6_ovf_cleared", {15'd0, overflow_out}, 16'h0000);
    rst = 0; tick();

    // halt freezes EVAL; flush on release beats a same-cycle capture
    to_eval(16'h8080, 3'd1, 1'b0);
    halted_in = 1; tick(); tick();
    chk("t7_halt_no_flush", {15'd0, flush_out}, 16'h0000);
    halted_in = 0; fetch_next_in = 1; lane0(1, 16'h9090, 3'd1); #1;
    chk("t7_flush", {15'd0, flush_out}, 16'h0001);
    tick();
    lane0(0, '0, 0);
    chk("t7_inject", inject_IR_out, 16'h8080);
    tick();
    flags_valid_in = 1;
    for (int k = 0; k < 4; k++) begin
      chk("t7_capture_dropped", {15'd0, flush_out | p0_do_delayed_B}, 16'h0000);
      tick();
    end
    flags_valid_in = 0;

    // NV entries are never stored
    fetch_next_in = 1;
    lane0(1, 16'hC001, 3'd0); lane1(1, 16'hC002, 3'd0);
    repeat (3) tick();
    lane0(0, '0, 0); lane1(0, '0, 0);
    chk("t8_nv_not_full", {15'd0, full_out}, 16'h0000);
    chk("t8_nv_no_ovf", {15'd0, overflow_out}, 16'h0000);
    fetch_next_in = 0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
